// File: rtl/stream_arb2.sv
// stream_arb2 -- two-source packet-level stream arbiter with a registered output.
//
// Two valid/ready sources (A and B) compete for one output stream. A grant is
// made in IDLE, then held for the whole packet until a beat with *_last is
// accepted. The FSM then returns to IDLE for one arbitration cycle. The output
// stage is a single registered beat that sustains one beat per cycle: a pop and
// a new transfer in the same cycle replace the beat with no bubble.
//
// Configuration macro: STREAM_ARB2_FIXED_PRIO_EN
//   undefined (default) : ties in IDLE are resolved round-robin via last_grant
//   defined             : ties in IDLE always go to source A
//
// Parameters:
//   DATA_W    width of the data path on every stream
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   a_valid    source A beat valid
//   a_data     source A beat data
//   a_last     source A final beat of a packet
//   a_ready    source A beat accepted (with a_valid)
//   b_valid    source B beat valid
//   b_data     source B beat data
//   b_last     source B final beat of a packet
//   b_ready    source B beat accepted (with b_valid)
//   out_valid  output beat valid
//   out_data   output beat data
//   out_last   output final beat of a packet
//   out_ready  downstream accepts the output beat
//   sel        current grant (0 = A, 1 = B), held through IDLE
module stream_arb2 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_last,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_last,
  output logic              b_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              sel
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_A = 2'd1,
    BUSY_B = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              sel_q, sel_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
`ifndef STREAM_ARB2_FIXED_PRIO_EN
  logic              last_grant_q, last_grant_d;
`endif

  logic              room;
  logic              xfer;
  logic              grant;
  logic              tie_grant;
  logic [DATA_W-1:0] in_data;
  logic              in_last;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
`ifndef STREAM_ARB2_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    a_ready = 1'b0;
    b_ready = 1'b0;
    grant   = 1'b0;

    // The output register can take a new beat when it is empty or being
    // popped this cycle; this is what gives full throughput.
    room = !out_valid_q || out_ready;

`ifdef STREAM_ARB2_FIXED_PRIO_EN
    tie_grant = 1'b0;
`else
    // last_grant holds the source that finished most recently; the other wins.
    tie_grant = ~last_grant_q;
`endif

    case (state_q)
      IDLE: begin
        if (a_valid && b_valid) begin
          grant = tie_grant;
        end else if (b_valid) begin
          grant = 1'b1;
        end
        if (a_valid || b_valid) begin
          state_d = grant ? BUSY_B : BUSY_A;
          sel_d   = grant;
        end
      end
      BUSY_A: begin
        a_ready = room;
        if (a_valid && room && a_last) begin
          state_d = IDLE;
`ifndef STREAM_ARB2_FIXED_PRIO_EN
          last_grant_d = 1'b0;
`endif
        end
      end
      BUSY_B: begin
        b_ready = room;
        if (b_valid && room && b_last) begin
          state_d = IDLE;
`ifndef STREAM_ARB2_FIXED_PRIO_EN
          last_grant_d = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    xfer    = (a_valid && a_ready) || (b_valid && b_ready);
    in_data = (state_q == BUSY_B) ? b_data : a_data;
    in_last = (state_q == BUSY_B) ? b_last : a_last;

    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data;
      out_last_d  = in_last;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
`ifndef STREAM_ARB2_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
`ifndef STREAM_ARB2_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign sel       = sel_q;

endmodule

// File: tb/tb_stream_arb2.sv
module tb_stream_arb2;

  logic       clk;
  logic       rst_n;
  logic       a_valid, a_last, a_ready;
  logic [7:0] a_data;
  logic       b_valid, b_last, b_ready;
  logic [7:0] b_data;
  logic       out_valid, out_last, out_ready;
  logic [7:0] out_data;
  logic       sel;
  logic [1:0] st;

  int n_vec = 0;
  int n_err = 0;

  stream_arb2 #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .sel(sel)
  );

  assign st = dut.state_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
    a_last = 1'b0; b_last = 1'b0; a_data = 8'h00; b_data = 8'h00;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
    a_last = 1'b0; b_last = 1'b0; a_data = 8'h00; b_data = 8'h00;
    cyc(); cyc();
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %h want 0", out_valid); end
    n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL rst_out_data got %h want 00", out_data); end
    n_vec++; if (out_last !== 1'b0) begin n_err++; $display("FAIL rst_out_last got %h want 0", out_last); end
    n_vec++; if (sel !== 1'b0) begin n_err++; $display("FAIL rst_sel got %h want 0", sel); end
    n_vec++; if (st !== 2'd0) begin n_err++; $display("FAIL rst_state got %h want 0", st); end
    rst_n = 1'b1;
    a_valid = 1'b1; b_valid = 1'b1;
    #1;
    n_vec++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL idle_a_ready got %h want 0", a_ready); end
    n_vec++; if (b_ready !== 1'b0) begin n_err++; $display("FAIL idle_b_ready got %h want 0", b_ready); end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_single;
    a_valid = 1'b1; a_data = 8'h11; a_last = 1'b1; out_ready = 1'b1;
    cyc();
    #1;
    n_vec++; if (st !== 2'd1) begin n_err++; $display("FAIL single_busy_a got %h want 1", st); end
    n_vec++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL single_a_ready got %h want 1", a_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid got %h want 0", out_valid); end
    cyc();
    a_valid = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_out_valid got %h want 1", out_valid); end
    n_vec++; if (out_data !== 8'h11) begin n_err++; $display("FAIL single_out_data got %h want 11", out_data); end
    n_vec++; if (out_last !== 1'b1) begin n_err++; $display("FAIL single_out_last got %h want 1", out_last); end
    n_vec++; if (sel !== 1'b0) begin n_err++; $display("FAIL single_sel got %h want 0", sel); end
    n_vec++; if (st !== 2'd0) begin n_err++; $display("FAIL single_idle got %h want 0", st); end
    cyc();
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_pop_valid got %h want 0", out_valid); end
    n_vec++; if (out_data !== 8'h11) begin n_err++; $display("FAIL single_hold_data got %h want 11", out_data); end
  endtask

  task automatic test_round_robin;
    logic [7:0] got [4];
    logic [7:0] exp [4];
    int np;
    logic acc_a, acc_b;
`ifdef STREAM_ARB2_FIXED_PRIO_EN
    exp[0] = 8'hA0; exp[1] = 8'hA1; exp[2] = 8'hA2; exp[3] = 8'hA3;
`else
    exp[0] = 8'hA0; exp[1] = 8'hB0; exp[2] = 8'hA1; exp[3] = 8'hB1;
`endif
    do_reset();
    a_valid = 1'b1; a_last = 1'b1; a_data = 8'hA0;
    b_valid = 1'b1; b_last = 1'b1; b_data = 8'hB0;
    np = 0;
    for (int c = 0; c < 20 && np < 4; c++) begin
      #1;
      if (out_valid && out_ready) begin got[np] = out_data; np++; end
      acc_a = a_valid && a_ready;
      acc_b = b_valid && b_ready;
      cyc();
      if (acc_a) a_data = a_data + 8'h01;
      if (acc_b) b_data = b_data + 8'h01;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    n_vec++;
    if (np != 4) begin
      n_err++; $display("FAIL rr_beat_count got %0d want 4", np);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (got[i] !== exp[i]) begin n_err++; $display("FAIL rr_beat%0d got %h want %h", i, got[i], exp[i]); end
      end
    end
  endtask

  task automatic test_lock;
    logic [7:0] got [4];
    logic       gsel [4];
    logic [7:0] exp [4];
    logic       esel [4];
    int np, bi;
    logic acc_a, acc_b;
    exp[0] = 8'h01; exp[1] = 8'h02; exp[2] = 8'h03; exp[3] = 8'h55;
    esel[0] = 1'b1; esel[1] = 1'b1; esel[2] = 1'b1; esel[3] = 1'b0;
    do_reset();
    b_valid = 1'b1; b_data = 8'h01; b_last = 1'b0;
    cyc();
    a_valid = 1'b1; a_data = 8'h55; a_last = 1'b1;
    np = 0; bi = 0;
    for (int c = 0; c < 20 && np < 4; c++) begin
      #1;
      if (out_valid && out_ready) begin got[np] = out_data; gsel[np] = sel; np++; end
      acc_a = a_valid && a_ready;
      acc_b = b_valid && b_ready;
      cyc();
      if (acc_b) begin
        bi++;
        if (bi == 3) b_valid = 1'b0;
        else begin b_data = 8'(bi + 1); b_last = (bi == 2); end
      end
      if (acc_a) a_valid = 1'b0;
    end
    n_vec++;
    if (np != 4) begin
      n_err++; $display("FAIL lock_beat_count got %0d want 4", np);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (got[i] !== exp[i]) begin n_err++; $display("FAIL lock_beat%0d got %h want %h", i, got[i], exp[i]); end
        n_vec++;
        if (gsel[i] !== esel[i]) begin n_err++; $display("FAIL lock_sel%0d got %h want %h", i, gsel[i], esel[i]); end
      end
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] got [4];
    int np, bi;
    logic acc_b;
    do_reset();
    b_valid = 1'b1; b_data = 8'h10; b_last = 1'b0;
    np = 0; bi = 0;
    for (int c = 0; c < 30 && np < 4; c++) begin
      out_ready = !(c >= 3 && c <= 6);
      #1;
      if (c >= 3 && c <= 6) begin
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid c%0d got %h want 1", c, out_valid); end
        n_vec++; if (out_data !== 8'h11) begin n_err++; $display("FAIL bp_data c%0d got %h want 11", c, out_data); end
        n_vec++; if (b_ready !== 1'b0) begin n_err++; $display("FAIL bp_b_ready c%0d got %h want 0", c, b_ready); end
      end
      if (out_valid && out_ready) begin got[np] = out_data; np++; end
      acc_b = b_valid && b_ready;
      cyc();
      if (acc_b) begin
        bi++;
        if (bi == 4) b_valid = 1'b0;
        else begin b_data = 8'(8'h10 + bi); b_last = (bi == 3); end
      end
    end
    out_ready = 1'b1;
    n_vec++;
    if (np != 4) begin
      n_err++; $display("FAIL bp_beat_count got %0d want 4", np);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (got[i] !== 8'(8'h10 + i)) begin n_err++; $display("FAIL bp_beat%0d got %h want %h", i, got[i], 8'(8'h10 + i)); end
      end
    end
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_extra_beat got %h want 0", out_valid); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    b_valid = 1'b1; b_data = 8'h21; b_last = 1'b0;
    cyc();
    cyc();
    b_data = 8'h22;
    #1;
    n_vec++; if (sel !== 1'b1) begin n_err++; $display("FAIL midrst_pre_sel got %h want 1", sel); end
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL midrst_pre_valid got %h want 1", out_valid); end
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1; b_valid = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid got %h want 0", out_valid); end
    n_vec++; if (st !== 2'd0) begin n_err++; $display("FAIL midrst_state got %h want 0", st); end
    n_vec++; if (sel !== 1'b0) begin n_err++; $display("FAIL midrst_sel got %h want 0", sel); end
    n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL midrst_data got %h want 00", out_data); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_quiet%0d got %h want 0", i, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stream_arb2.md
STREAM_ARB2 -- requirements
Module: stream_arb2

Interface
REQ-001 SHALL have parameter: DATA_W, default 8, width of the data path on every stream.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning (clock and reset first):
- clk  input  1  single system clock; all state changes on the rising edge
- rst_n  input  1  reset, synchronous, active-low
- a_valid  input  1  source A beat valid
- a_data  input  DATA_W  source A beat data
- a_last  input  1  source A final beat of a packet
- a_ready  output  1  source A beat accepted when high with a_valid
- b_valid  input  1  source B beat valid
- b_data  input  DATA_W  source B beat data
- b_last  input  1  source B final beat of a packet
- b_ready  output  1  source B beat accepted when high with b_valid
- out_valid  output  1  output beat valid
- out_data  output  DATA_W  output beat data
- out_last  output  1  output final beat of a packet
- out_ready  input  1  downstream accepts the output beat
- sel  output  1  current grant: 0 = A, 1 = B; feeds the downstream 2:1 select

Function
REQ-003 SHALL implement FSM states IDLE, BUSY_A and BUSY_B, held in registers.
REQ-004 In IDLE, SHALL drive a_ready = b_ready = 0.
REQ-005 IDLE with only a_valid SHALL go to BUSY_A next cycle; with only b_valid, to BUSY_B; with neither, stay IDLE.
REQ-006 IDLE with both valid SHALL grant the source not granted last (round-robin, last_grant register), unless REQ-017 applies.
REQ-007 On entering BUSY_x, SHALL set sel to the granted source in the same edge; sel SHALL hold its value through IDLE.
REQ-008 In BUSY_x, SHALL drive x_ready = (!out_valid || out_ready); the non-granted ready SHALL be 0.
REQ-009 A transfer occurs when x_valid && x_ready; on that edge out_data/out_last SHALL load x_data/x_last and out_valid SHALL become 1 (one-cycle latency, registered output).
REQ-010 When out_valid && out_ready with no new transfer, out_valid SHALL clear next edge; out_data SHALL hold.
REQ-011 Simultaneous output pop and input transfer in the same cycle SHALL replace the output beat with no bubble (full throughput, one beat per cycle).
REQ-012 A transfer with x_last = 1 SHALL return the FSM to IDLE and set last_grant = x; grant SHALL be locked to x until then.
REQ-013 While out_valid && !out_ready, out_data, out_last and out_valid SHALL remain stable.
REQ-014 Minimum packet-to-packet gap on the input side SHALL be one cycle (the IDLE arbitration cycle).

Reset
REQ-015 When rst_n = 0 at a rising edge, SHALL set state = IDLE, out_valid = 0, out_data = 0, out_last = 0, sel = 0, last_grant = B (so A wins the first tie).
REQ-016 Reset mid-packet SHALL discard the packet in progress and the buffered output beat, with no further beats emitted.

Configuration
REQ-017 Macro STREAM_ARB2_FIXED_PRIO_EN: when defined, a tie in IDLE SHALL always grant A and last_grant is unused; when undefined, round-robin per REQ-006.

Verification
REQ-018 Reset then a_valid = 1, a_data = 0x11, a_last = 1, out_ready = 1 -> BUSY_A on cycle 1, a_ready = 1 on cycle 1, out_valid = 1 with out_data = 0x11 and out_last = 1 on cycle 2, sel = 0, FSM back in IDLE.
REQ-019 Both sources continuously valid with single-beat packets (A = 0xA0.., B = 0xB0..) -> outputs alternate A,B,A,B; with STREAM_ARB2_FIXED_PRIO_EN defined -> only A beats appear.
REQ-020 3-beat B packet 0x01,0x02,0x03 (last on 0x03) while A is valid -> no A beat interleaves, sel = 1 throughout, then A is granted next.
REQ-021 out_ready = 0 for 4 cycles mid-packet -> out_data stable, b_ready = 0 after the buffer fills; resume -> no beat lost or duplicated.
REQ-022 rst_n = 0 for one cycle during the 2nd beat of a packet -> next cycle out_valid = 0, state IDLE, sel = 0.
